regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Single-port access controller sitting directly upstream of the register bank.
//  Accepts read/write requests over a valid/ready handshake and decodes the address
//  into one-hot per-register read/write strobes. Write data goes out on a shared bus;
//  read data is sampled from the shared tri-state read bus and returned on a
//  response channel. One request is in flight at a time.
// PARAMETERS
//  DATA_WIDTH  16  width of register data, write bus and read bus
//  NUM_REGS    8   number of registers driven (strobe vector width)
//  ADDR_WIDTH  3   request address width; must be >= clog2(NUM_REGS)
// PORTS
//  clk            in   1           single clock, all state updates on posedge
//  rst            in   1           asynchronous, active-high reset
//  req_valid      in   1           request present
//  req_ready      out  1           controller can accept (high only in IDLE)
//  req_write      in   1           1 = write, 0 = read
//  req_addr       in   ADDR_WIDTH  target register index
//  req_wdata      in   DATA_WIDTH  write data
//  rsp_valid      out  1           read data valid
//  rsp_ready      in   1           consumer takes response
//  rsp_data       out  DATA_WIDTH  read data
//  reg_write_en   out  NUM_REGS    one-hot write strobes to register bank
//  reg_read_en    out  NUM_REGS    one-hot read strobes to register bank
//  reg_write_data out  DATA_WIDTH  shared write bus
//  reg_read_bus   in   DATA_WIDTH  shared tri-state read bus from register bank
// BEHAVIOUR
//  - FSM states: IDLE, WRITE, READ, RESP. All outputs registered.
//  - Reset (async, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0,
//    reg_write_en=0, reg_read_en=0, reg_write_data=0. In-flight request is dropped.
//  - IDLE: req_ready=1. Accept on req_valid&&req_ready at posedge T; latch addr/data.
//    Go to WRITE if req_write, else READ. Accepted cycle is T+1.
//  - WRITE (cycle T+1): reg_write_en=onehot(addr), reg_write_data=latched data,
//    for exactly 1 cycle. The register captures at the posedge ending T+1.
//    Then IDLE, so req_ready=1 in T+2. Writes produce no response.
//  - READ (cycle T+1): reg_read_en=onehot(addr) for exactly 1 cycle. The bank drives
//    reg_read_bus on the negedge inside T+1. rsp_data captures reg_read_bus at the
//    posedge ending T+1. Then RESP.
//  - RESP: rsp_valid=1 from T+2; rsp_data held stable until rsp_valid&&rsp_ready.
//    Then IDLE, with req_ready=1 on the next cycle. Read latency is 2 cycles
//    (accept -> rsp_valid).
//  - At most one bit of reg_write_en | reg_read_en is high in any cycle. Both vectors
//    are all-zero in IDLE and RESP.
//  - Out-of-range address (addr >= NUM_REGS): no strobe is raised. A write is
//    silently dropped. A read still takes the READ/RESP path and returns rsp_data=0.
//  - req_* are ignored while req_ready=0. A new request is never accepted in the
//    same cycle a response is consumed.
//  - rst asserted during WRITE: the strobe drops immediately and the write may be
//    lost. rst asserted during RESP: the response is discarded.
// CONFIGURATION
//  ZERO_REG_EN defined: register index 0 is hardwired zero. Writes to addr 0 raise no
//    strobe (dropped). Reads of addr 0 raise no strobe and return rsp_data=0 with
//    normal 2-cycle latency.
//  ZERO_REG_EN undefined: addr 0 behaves like any other register.
// TESTING
//  1. Reset: rst=1 mid-READ -> all strobes 0, rsp_valid=0, rsp_data=0, req_ready=1
//     immediately (async).
//  2. Write addr 3, data 16'hA5A5 -> reg_write_en=8'b0000_1000 for exactly 1 cycle,
//     reg_write_data=A5A5; req_ready back to 1 two cycles after accept.
//  3. Write 5<=16'h1234, then read 5 -> reg_read_en=8'b0010_0000 for 1 cycle;
//     rsp_valid=1 two cycles after accept; rsp_data=16'h1234.
//  4. Backpressure: read completes with rsp_ready=0 for 4 cycles -> rsp_valid and
//     rsp_data stable, req_ready=0 throughout; IDLE only after the handshake.
//  5. NUM_REGS=6, ADDR_WIDTH=3: write addr 7 -> no strobe; read addr 7 -> rsp_data=0.
//  6. ZERO_REG_EN defined: write addr 0 data FFFF -> no strobe; read addr 0 ->
//     rsp_data=0. Undefined: strobe bit 0 is raised and data is returned from the bus.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_port_ctrl
// Single-port access controller in front of a register bank. Takes one
// read/write request at a time over valid/ready and decodes the address into
// one-hot per-register strobes. Write data is driven on a shared bus. Read data
// is sampled from the shared read bus and returned on a response channel.
// Every output comes straight from a flop.
//
// Optional feature macro: ZERO_REG_EN
//   defined   : register index 0 is hardwired zero. Accesses to it raise no
//               strobe, writes are dropped and reads return zero.
//   undefined : index 0 behaves like any other register.
// ----------------------------------------------------------------------------
module regfile_port_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [NUM_REGS-1:0]   o_reg_write_en,
  output logic [NUM_REGS-1:0]   o_reg_read_en,
  output logic [DATA_WIDTH-1:0] o_reg_write_data,
  input  logic [DATA_WIDTH-1:0] i_reg_read_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Remembers whether the accepted address maps to a real register, so the
  // READ cycle knows whether the bus is actually being driven.
  logic                  r_addr_ok;
  logic                  w_addr_ok_nxt;

  logic                  r_req_ready;
  logic                  w_req_ready_nxt;
  logic                  r_rsp_valid;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [DATA_WIDTH-1:0] w_rsp_data_nxt;
  logic [NUM_REGS-1:0]   r_write_en;
  logic [NUM_REGS-1:0]   w_write_en_nxt;
  logic [NUM_REGS-1:0]   r_read_en;
  logic [NUM_REGS-1:0]   w_read_en_nxt;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [DATA_WIDTH-1:0] w_write_data_nxt;

  logic                  w_req_addr_ok;
  logic [NUM_REGS-1:0]   w_req_onehot;

  // Address qualification and one-hot decode of the incoming request address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_req_addr_ok = (int'(i_req_addr) < NUM_REGS);
`ifdef ZERO_REG_EN
    w_req_addr_ok = w_req_addr_ok && (i_req_addr != '0);
`endif
    w_req_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_req_onehot[i] = w_req_addr_ok && (int'(i_req_addr) == i);
    end
  end

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_ok_nxt    = r_addr_ok;
    w_req_ready_nxt  = r_req_ready;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;
    w_write_en_nxt   = '0;
    w_read_en_nxt    = '0;
    w_write_data_nxt = r_write_data;

    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          w_addr_ok_nxt   = w_req_addr_ok;
          if (i_req_write) begin
            w_state_nxt      = S_WRITE;
            w_write_en_nxt   = w_req_onehot;
            w_write_data_nxt = i_req_wdata;
          end else begin
            w_state_nxt   = S_READ;
            w_read_en_nxt = w_req_onehot;
          end
        end
      end

      S_WRITE: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      S_READ: begin
        // Nothing drives the bus for an unmapped address, so return zero.
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = r_addr_ok ? i_reg_read_bus : '0;
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr_ok    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_write_en   <= '0;
      r_read_en    <= '0;
      r_write_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_state      <= w_state_nxt;
      r_addr_ok    <= w_addr_ok_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_write_en   <= w_write_en_nxt;
      r_read_en    <= w_read_en_nxt;
      r_write_data <= w_write_data_nxt;
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_data       = r_rsp_data;
  assign o_reg_write_en   = r_write_en;
  assign o_reg_read_en    = r_read_en;
  assign o_reg_write_data = r_write_data;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_port_ctrl
// Two controllers share one behavioural register bank: dut_a has 8 registers,
// dut_b has 6 so that addresses 6 and 7 fall outside its range. A select flag
// chooses which one is stimulated and observed. Read results expected from a
// shadow copy of the register contents are queued at request time and popped
// when the response handshake happens.
// ----------------------------------------------------------------------------
module tb_regfile_port_ctrl;

  localparam int DW   = 16;
  localparam int NR   = 8;
  localparam int NR_B = 6;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_ready;
  logic [DW-1:0] read_bus;

  logic            a_req_ready, a_rsp_valid;
  logic [DW-1:0]   a_rsp_data, a_wd;
  logic [NR-1:0]   a_we, a_re;
  logic            b_req_ready, b_rsp_valid;
  logic [DW-1:0]   b_rsp_data, b_wd;
  logic [NR_B-1:0] b_we, b_re;

  logic            cur_ready, cur_rsp_valid;
  logic [DW-1:0]   cur_rsp_data, cur_wd;
  logic [NR-1:0]   cur_we, cur_re;

  logic [DW-1:0]   bank [NR];
  logic [DW-1:0]   exp_mem [NR];
  logic [DW-1:0]   sb_q [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid && !sel), .o_req_ready(a_req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(a_rsp_data),
    .o_reg_write_en(a_we), .o_reg_read_en(a_re), .o_reg_write_data(a_wd),
    .i_reg_read_bus(read_bus)
  );

  regfile_port_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR_B), .ADDR_WIDTH(AW)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid && sel), .o_req_ready(b_req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(b_rsp_data),
    .o_reg_write_en(b_we), .o_reg_read_en(b_re), .o_reg_write_data(b_wd),
    .i_reg_read_bus(read_bus)
  );

  assign cur_ready     = sel ? b_req_ready : a_req_ready;
  assign cur_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign cur_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign cur_wd        = sel ? b_wd        : a_wd;
  assign cur_we        = sel ? {2'b00, b_we} : a_we;
  assign cur_re        = sel ? {2'b00, b_re} : a_re;

  // Register bank: captures on the posedge ending a strobe cycle.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst)            bank[i] <= '0;
      else if (cur_we[i]) bank[i] <= cur_wd;
    end
  end

  // Read bus: driven on the negedge inside a read-strobe cycle, junk otherwise.
  always @(negedge clk) begin
    logic [DW-1:0] v;
    v = 16'hDEAD;
    for (int i = 0; i < NR; i++) if (cur_re[i]) v = bank[i];
    read_bus <= v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lands(input logic [AW-1:0] addr);
    bit ok;
    ok = (int'(addr) < (sel ? NR_B : NR));
`ifdef ZERO_REG_EN
    if (addr == 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] exp_oh(input logic [AW-1:0] addr);
    return lands(addr) ? (32'd1 << addr) : 32'd0;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cur_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cur_ready) check("ready_timeout", 32'(cur_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0;
    check("wr_strobe", 32'(cur_we), exp_oh(addr));
    check("wr_no_read_strobe", 32'(cur_re), 32'd0);
    check("wr_ready_low", 32'(cur_ready), 32'd0);
    if (lands(addr)) begin
      check("wr_data", 32'(cur_wd), 32'(data));
      exp_mem[addr] = data;
    end
    tick();
    check("wr_strobe_drop", 32'(cur_we), 32'd0);
    check("wr_ready_back", 32'(cur_ready), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int stall);
    wait_ready();
    sb_q.push_back(lands(addr) ? exp_mem[addr] : '0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    check("rd_strobe", 32'(cur_re), exp_oh(addr));
    check("rd_no_write_strobe", 32'(cur_we), 32'd0);
    check("rd_valid_early", 32'(cur_rsp_valid), 32'd0);
    tick();
    check("rd_strobe_drop", 32'(cur_re), 32'd0);
    check("rd_latency", 32'(cur_rsp_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("bp_valid_hold", 32'(cur_rsp_valid), 32'd1);
      check("bp_data_hold", 32'(cur_rsp_data), 32'(sb_q[0]));
      check("bp_ready_low", 32'(cur_ready), 32'd0);
      tick();
    end
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      check("rd_data", 32'(cur_rsp_data), 32'(sb_q.pop_front()));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_consumed", 32'(cur_rsp_valid), 32'd0);
    check("rsp_ready_back", 32'(cur_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) exp_mem[i] = '0;
    repeat (3) tick();
    check("rst_ready", 32'(a_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(a_rsp_data), 32'd0);
    check("rst_strobes", {16'(a_we), 16'(a_re)}, 32'd0);
    check("rst_wdata", 32'(a_wd), 32'd0);
    rst = 1'b0;
    tick();

    // Reset asserted while a read strobe is active.
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd2;
    tick();
    req_valid = 1'b0;
    check("mid_read_strobe", 32'(a_re), 32'h4);
    #1 rst = 1'b1;
    #1;
    check("async_rst_read_en", 32'(a_re), 32'd0);
    check("async_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("async_rst_rsp_data", 32'(a_rsp_data), 32'd0);
    check("async_rst_ready", 32'(a_req_ready), 32'd1);
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_no_rsp", 32'(a_rsp_valid), 32'd0);

    // Basic writes and reads, including backpressure.
    do_write(3'd3, 16'hA5A5);
    do_write(3'd5, 16'h1234);
    do_read(3'd5, 0);
    do_write(3'd1, 16'hBEEF);
    do_read(3'd1, 4);
    do_read(3'd3, 1);

    // Six-register controller: addresses 6 and 7 are out of range.
    sel = 1'b1;
    tick();
    do_write(3'd7, 16'hFFFF);
    do_read(3'd7, 0);
    do_write(3'd6, 16'h5555);
    do_read(3'd6, 2);
    do_read(3'd5, 0);
    sel = 1'b0;
    tick();

    // Register 0: hardwired zero when the feature is built in.
    do_write(3'd0, 16'hFFFF);
    do_read(3'd0, 0);

    // A short pseudo-random mix on the eight-register controller.
    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(NR - 1, 0));
      if ($urandom_range(1, 0) == 1) do_write(a, DW'($urandom));
      else                           do_read(a, int'($urandom_range(2, 0)));
    end

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
